sub8_serial: RTL



---
 rtl/sub8_serial_if.sv | 25 ++
 rtl/sub8_serial.sv | 106 ++++++++++
 2 files changed

// File: rtl/sub8_serial_if.sv
// Operand/result bundle for the bit-serial subtractor sub8_serial.
// Handshake: a start is accepted on a rising edge when busy is low; done pulses for one cycle with results.
interface sub8_serial_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       sign;
    logic       overflow;
    logic       borrow_out;
    logic       zero;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, sign, overflow, borrow_out, zero
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, sign, overflow, borrow_out, zero
    );
endinterface

// File: rtl/sub8_serial.sv
// Bit-serial 8-bit subtractor: diff = a - b - borrow_in, LSB first over eight clocks.
// Optional macro SUB8_SATURATE_EN clamps diff on signed overflow.
module sub8_serial (
    input  logic               clk,
    input  logic               rst_n,
    sub8_serial_if.slave       s_bus,
    output logic [1:0]         o_state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_br;
    logic [2:0] r_cnt;
    logic [6:0] r_acc;
    logic [7:0] r_diff;
    logic       r_sign;
    logic       r_ovf;
    logic       r_bout;
    logic       r_zero;

    logic       w_abit;
    logic       w_bbit;
    logic       w_d;
    logic       w_nbr;
    logic       w_accept;
    logic       w_last;
    logic [7:0] w_raw;
    logic       w_ovf;
    logic [7:0] w_res;

    // Operands shift right so bit 0 is always the bit being processed.
    assign w_abit   = r_a[0];
    assign w_bbit   = r_b[0];
    assign w_d      = w_abit ^ w_bbit ^ r_br;
    assign w_nbr    = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_br);
    assign w_accept = s_bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == 3'd7);
    assign w_raw    = {w_d, r_acc};
    // On the last bit w_abit/w_bbit are a[7]/b[7] and w_d is diff[7].
    assign w_ovf    = (w_abit != w_bbit) && (w_d != w_abit);

`ifdef SUB8_SATURATE_EN
    assign w_res = w_ovf ? (w_abit ? 8'h80 : 8'h7F) : w_raw;
`else
    assign w_res = w_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_br    <= 1'b0;
            r_cnt   <= 3'd0;
            r_acc   <= 7'h00;
            r_diff  <= 8'h00;
            r_sign  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a     <= s_bus.a;
                        r_b     <= s_bus.b;
                        r_br    <= s_bus.borrow_in;
                        r_cnt   <= 3'd0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_nbr;
                    r_acc <= w_raw[7:1];
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_diff  <= w_res;
                        r_sign  <= w_res[7];
                        r_ovf   <= w_ovf;
                        r_bout  <= w_nbr;
                        r_zero  <= (w_res == 8'h00);
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_bus.busy       = (r_state == ST_SHIFT);
    assign s_bus.done       = (r_state == ST_DONE);
    assign s_bus.diff       = r_diff;
    assign s_bus.sign       = r_sign;
    assign s_bus.overflow   = r_ovf;
    assign s_bus.borrow_out = r_bout;
    assign s_bus.zero       = r_zero;
    assign o_state          = r_state;
endmodule
